// File: rtl/game_round_controller_pkg.sv
// Shared definitions for the game round controller: state encoding,
// default session constants and the speed table defaults used by the sprite logic.
package game_round_controller_pkg;

    typedef enum logic [1:0] {
        ATTRACT = 2'd0,
        PLAY    = 2'd1,
        EVAL    = 2'd2,
        WAIT    = 2'd3
    } round_state_t;

    localparam int DEFAULT_INIT_LIVES     = 3;
    localparam int DEFAULT_LIVES_W        = 3;
    localparam int DEFAULT_LEVEL_W        = 3;
    localparam int DEFAULT_MAX_LEVEL      = 7;
    localparam int DEFAULT_WINS_PER_LEVEL = 3;
    localparam int DEFAULT_SCORE_W        = 16;

    localparam int DEFAULT_SPEED_W        = 4;
    localparam int DEFAULT_BASE_SPEED     = 1;
    localparam int DEFAULT_SPEED_STEP     = 1;

    localparam int BCD_DIGITS             = 4;

endpackage

// File: rtl/game_bcd_digit.sv
// One BCD digit incrementer: adds carry_in, wraps 9->0 with carry out,
// and flags a digit sitting at 9 so the caller can saturate the whole number.
module game_bcd_digit (
    input  logic [3:0] digit,
    input  logic       carry_in,
    output logic [3:0] digit_next,
    output logic       carry_out,
    output logic       saturate
);

    always_comb begin
        saturate   = (digit == 4'd9);
        carry_out  = carry_in & saturate;
        digit_next = digit;
        if (carry_in) begin
            digit_next = saturate ? 4'd0 : digit + 4'd1;
        end
    end

endmodule

// File: rtl/game_round_controller.sv
// Session scheduler above the master game FSM: rounds, score, lives, level, target speed.
// Define GAME_SCORE_BCD_EN for a 4-digit packed BCD score (SCORE_W must then be 16).
module game_round_controller
    import game_round_controller_pkg::*;
#(
    parameter int INIT_LIVES     = DEFAULT_INIT_LIVES,
    parameter int LIVES_W        = DEFAULT_LIVES_W,
    parameter int LEVEL_W        = DEFAULT_LEVEL_W,
    parameter int MAX_LEVEL      = DEFAULT_MAX_LEVEL,
    parameter int WINS_PER_LEVEL = DEFAULT_WINS_PER_LEVEL,
    parameter int SCORE_W        = DEFAULT_SCORE_W,
    parameter int SPEED_W        = DEFAULT_SPEED_W,
    parameter int BASE_SPEED     = DEFAULT_BASE_SPEED,
    parameter int SPEED_STEP     = DEFAULT_SPEED_STEP
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               key,
    input  logic               end_of_game_timer_start,
    input  logic               game_won,
    input  logic               end_of_game_timer_running,
    output logic               master_enable,
    output logic               game_over,
    output logic [SCORE_W-1:0] score,
    output logic [LIVES_W-1:0] lives,
    output logic [LEVEL_W-1:0] level,
    output logic [SPEED_W-1:0] target_speed
);

    localparam int STREAK_W     = $clog2(WINS_PER_LEVEL + 1);
    localparam int SPEED_WIDE_W = SPEED_W + LEVEL_W;
    localparam logic [SPEED_WIDE_W-1:0] SPEED_CAP = SPEED_WIDE_W'((1 << SPEED_W) - 1);

    round_state_t          state_reg;
    logic                  key_q_reg;
    logic [STREAK_W-1:0]   streak_reg;

    logic                  key_rise;
    logic [STREAK_W-1:0]   streak_next;
    logic                  level_up;
    logic [SCORE_W-1:0]    score_next;
    logic [SPEED_WIDE_W-1:0] speed_wide;
    logic [SPEED_W-1:0]    speed_next;

    assign key_rise    = key & ~key_q_reg;
    assign streak_next = streak_reg + STREAK_W'(1);
    assign level_up    = (streak_next == STREAK_W'(WINS_PER_LEVEL));

    // Wide sum so a high level cannot wrap before the clamp is applied.
    always_comb begin
        speed_wide = SPEED_WIDE_W'(BASE_SPEED) + SPEED_WIDE_W'(level) * SPEED_WIDE_W'(SPEED_STEP);
        speed_next = (speed_wide > SPEED_CAP) ? SPEED_CAP[SPEED_W-1:0] : speed_wide[SPEED_W-1:0];
    end

`ifdef GAME_SCORE_BCD_EN
    logic [BCD_DIGITS-1:0]   digit_carry_in;
    logic [BCD_DIGITS-1:0]   digit_carry_out;
    logic [BCD_DIGITS-1:0]   digit_sat;
    logic [4*BCD_DIGITS-1:0] bcd_sum;

    assign digit_carry_in = {digit_carry_out[BCD_DIGITS-2:0], 1'b1};

    generate
        for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_bcd
            game_bcd_digit u_digit (
                .digit      (score[gi*4 +: 4]),
                .carry_in   (digit_carry_in[gi]),
                .digit_next (bcd_sum[gi*4 +: 4]),
                .carry_out  (digit_carry_out[gi]),
                .saturate   (digit_sat[gi])
            );
        end
    endgenerate

    // All-nines is the only value that carries out of the top digit.
    assign score_next = ((&digit_sat) | digit_carry_out[BCD_DIGITS-1]) ? score : bcd_sum;
`else
    assign score_next = (&score) ? score : score + SCORE_W'(1);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ATTRACT;
            game_over     <= 1'b1;
            master_enable <= 1'b0;
            score         <= '0;
            lives         <= '0;
            level         <= '0;
            streak_reg    <= '0;
            target_speed  <= SPEED_W'(BASE_SPEED);
            key_q_reg     <= 1'b1;
        end else begin
            key_q_reg    <= key;
            target_speed <= speed_next;
            case (state_reg)
                ATTRACT: begin
                    if (key_rise) begin
                        score         <= '0;
                        lives         <= LIVES_W'(INIT_LIVES);
                        level         <= '0;
                        streak_reg    <= '0;
                        state_reg     <= PLAY;
                        game_over     <= 1'b0;
                        master_enable <= 1'b1;
                    end
                end
                PLAY: begin
                    if (end_of_game_timer_start) begin
                        state_reg <= EVAL;
                    end
                end
                EVAL: begin
                    if (game_won) begin
                        score <= score_next;
                        if (level_up) begin
                            streak_reg <= '0;
                            if (level != LEVEL_W'(MAX_LEVEL)) begin
                                level <= level + LEVEL_W'(1);
                            end
                        end else begin
                            streak_reg <= streak_next;
                        end
                    end else begin
                        if (lives != '0) begin
                            lives <= lives - LIVES_W'(1);
                        end
                        streak_reg <= '0;
                    end
                    state_reg <= WAIT;
                end
                WAIT: begin
                    // Master FSM stays enabled so its end-of-round timer can finish.
                    if (!end_of_game_timer_running) begin
                        if (lives == '0) begin
                            state_reg     <= ATTRACT;
                            game_over     <= 1'b1;
                            master_enable <= 1'b0;
                        end else begin
                            state_reg <= PLAY;
                        end
                    end
                end
                default: begin
                    state_reg     <= ATTRACT;
                    game_over     <= 1'b1;
                    master_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule
